// File: rtl/aqua_pkg.sv
// Shared types and constants for the aqua integer register file and its neighbours.
package aqua_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1_addr_instr1;
        logic [REG_ADDR_W-1:0] rs2_addr_instr1;
        logic [REG_ADDR_W-1:0] rs1_addr_instr2;
        logic [REG_ADDR_W-1:0] rs2_addr_instr2;
    } rs_addr_s;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data_instr1;
        logic [XLEN-1:0] rs2_data_instr1;
        logic [XLEN-1:0] rs1_data_instr2;
        logic [XLEN-1:0] rs2_data_instr2;
    } rs_data_s;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr_instr1;
        logic [REG_ADDR_W-1:0] rd_addr_instr2;
        logic [XLEN-1:0]       rd_data_instr1;
        logic [XLEN-1:0]       rd_data_instr2;
        logic                  wren_instr1;
        logic                  wren_instr2;
    } writeback_s;

endpackage

// File: rtl/aqua_rf_read_port.sv
// One combinational read port: x0 / writeback bypass / stored value selection.
module rf_read_port
    import aqua_pkg::*;
(
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] addr,
    input  writeback_s            wb,
    input  logic [XLEN-1:0]       stored,
    output logic [XLEN-1:0]       data
);

    logic hit_instr1;
    logic hit_instr2;

    assign hit_instr1 = wb.wren_instr1 && (wb.rd_addr_instr1 == addr);
    assign hit_instr2 = wb.wren_instr2 && (wb.rd_addr_instr2 == addr);

    // instr2 is younger, so its writeback wins over instr1 for the same register.
    always_comb begin
        data = stored;
        if (!rst_n || addr == '0) begin
            data = '0;
        end else if (hit_instr2) begin
            data = wb.rd_data_instr2;
        end else if (hit_instr1) begin
            data = wb.rd_data_instr1;
        end
    end

endmodule

// File: rtl/aqua_regfile.sv
// 32 x 32-bit integer register file: four bypassed read ports, two write ports.
module aqua_regfile
    import aqua_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  rs_addr_s   i_sch_rf_pkg,
    input  writeback_s i_wb_rf_pkg,
    output rs_data_s   o_rf_abt_pkg
);

    // Writes are unconditional strobes: a set wren is always accepted, no back-pressure.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];
    logic [XLEN-1:0] view [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (i_wb_rf_pkg.wren_instr1 && i_wb_rf_pkg.rd_addr_instr1 != '0) begin
                regs[i_wb_rf_pkg.rd_addr_instr1] <= i_wb_rf_pkg.rd_data_instr1;
            end
            // Issued after instr1 so a same-address double write keeps instr2's data.
            if (i_wb_rf_pkg.wren_instr2 && i_wb_rf_pkg.rd_addr_instr2 != '0) begin
                regs[i_wb_rf_pkg.rd_addr_instr2] <= i_wb_rf_pkg.rd_data_instr2;
            end
        end
    end

    always_comb begin
        view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            view[i] = regs[i];
        end
    end

    rf_read_port u_rs1_instr1 (
        .rst_n  (i_rst_n),
        .addr   (i_sch_rf_pkg.rs1_addr_instr1),
        .wb     (i_wb_rf_pkg),
        .stored (view[i_sch_rf_pkg.rs1_addr_instr1]),
        .data   (o_rf_abt_pkg.rs1_data_instr1)
    );

    rf_read_port u_rs2_instr1 (
        .rst_n  (i_rst_n),
        .addr   (i_sch_rf_pkg.rs2_addr_instr1),
        .wb     (i_wb_rf_pkg),
        .stored (view[i_sch_rf_pkg.rs2_addr_instr1]),
        .data   (o_rf_abt_pkg.rs2_data_instr1)
    );

    rf_read_port u_rs1_instr2 (
        .rst_n  (i_rst_n),
        .addr   (i_sch_rf_pkg.rs1_addr_instr2),
        .wb     (i_wb_rf_pkg),
        .stored (view[i_sch_rf_pkg.rs1_addr_instr2]),
        .data   (o_rf_abt_pkg.rs1_data_instr2)
    );

    rf_read_port u_rs2_instr2 (
        .rst_n  (i_rst_n),
        .addr   (i_sch_rf_pkg.rs2_addr_instr2),
        .wb     (i_wb_rf_pkg),
        .stored (view[i_sch_rf_pkg.rs2_addr_instr2]),
        .data   (o_rf_abt_pkg.rs2_data_instr2)
    );

endmodule

// File: tb/tb_aqua_regfile.sv
// Scoreboard bench for aqua_regfile: directed plan followed by randomized dual-issue traffic.
module tb_aqua_regfile;
    import aqua_pkg::*;

    logic       clk;
    logic       rst_n;
    rs_addr_s   rs;
    writeback_s wb;
    rs_data_s   rd;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] mdl [NUM_REGS];
    int checks   = 0;
    int failures = 0;

    aqua_regfile dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sch_rf_pkg (rs),
        .i_wb_rf_pkg  (wb),
        .o_rf_abt_pkg (rd)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drivers
    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        rs.rs1_addr_instr1 = a0;
        rs.rs2_addr_instr1 = a1;
        rs.rs1_addr_instr2 = a2;
        rs.rs2_addr_instr2 = a3;
    endtask

    task automatic set_wb(input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic w2, input logic [4:0] a2, input logic [31:0] d2);
        wb.wren_instr1    = w1;
        wb.rd_addr_instr1 = a1;
        wb.rd_data_instr1 = d1;
        wb.wren_instr2    = w2;
        wb.rd_addr_instr2 = a2;
        wb.rd_data_instr2 = d2;
    endtask

    task automatic expect4(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    // Scoreboard: pop four expectations and compare against the four ports.
    task automatic compare4(input string tag);
        logic [31:0] obs [4];
        #2;
        obs[0] = rd.rs1_data_instr1;
        obs[1] = rd.rs2_data_instr1;
        obs[2] = rd.rs1_data_instr2;
        obs[3] = rd.rs2_data_instr2;
        for (int p = 0; p < 4; p++) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_p%0d scoreboard empty", tag, p);
            end else begin
                check($sformatf("%s_p%0d", tag, p), obs[p], exp_q.pop_front());
            end
        end
    endtask

    // Reference behaviour: x0 reads 0, then instr2 bypass, instr1 bypass, stored value.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (wb.wren_instr2 && wb.rd_addr_instr2 == a) return wb.rd_data_instr2;
        if (wb.wren_instr1 && wb.rd_addr_instr1 == a) return wb.rd_data_instr1;
        return mdl[a];
    endfunction

    task automatic cycle();
        if (rst_n) begin
            if (wb.wren_instr1 && wb.rd_addr_instr1 != 5'd0) mdl[wb.rd_addr_instr1] = wb.rd_data_instr1;
            if (wb.wren_instr2 && wb.rd_addr_instr2 != 5'd0) mdl[wb.rd_addr_instr2] = wb.rd_data_instr2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
        rst_n = 1'b0;
        set_rd(5'd1, 5'd2, 5'd3, 5'd4);
        set_wb(1'b1, 5'd1, 32'h5555_5555, 1'b1, 5'd2, 32'h6666_6666);
        @(negedge clk);
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        compare4("in_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // x0 reads plus same-cycle forwarding of two writes
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        set_wb(1'b1, 5'd1, 32'h1234_5678, 1'b1, 5'd2, 32'hABCD_6789);
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        compare4("x0_read");
        set_rd(5'd1, 5'd2, 5'd2, 5'd1);
        expect4(32'h1234_5678, 32'hABCD_6789, 32'hABCD_6789, 32'h1234_5678);
        compare4("fwd_x1_x2");
        cycle();

        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_rd(5'd2, 5'd1, 5'd0, 5'd0);
        expect4(32'hABCD_6789, 32'h1234_5678, 32'h0, 32'h0);
        compare4("stored_x1_x2");

        set_wb(1'b1, 5'd10, 32'h0000_ABCD, 1'b1, 5'd11, 32'h0000_1234);
        cycle();
        set_wb(1'b1, 5'd20, 32'hA0A0_A0A0, 1'b1, 5'd21, 32'hB0B0_B0B0);
        cycle();
        set_wb(1'b0, 5'd1, 32'h7777_7777, 1'b0, 5'd10, 32'h8888_8888);
        set_rd(5'd21, 5'd11, 5'd10, 5'd20);
        expect4(32'hB0B0_B0B0, 32'h0000_1234, 32'h0000_ABCD, 32'hA0A0_A0A0);
        compare4("stored_4regs");
        cycle();
        set_rd(5'd1, 5'd10, 5'd1, 5'd10);
        expect4(32'h1234_5678, 32'h0000_ABCD, 32'h1234_5678, 32'h0000_ABCD);
        compare4("no_wren_no_store");

        // Bypass over already-stored values
        set_wb(1'b1, 5'd1, 32'h1122_3344, 1'b1, 5'd10, 32'hAABB_CCDD);
        set_rd(5'd1, 5'd10, 5'd20, 5'd21);
        expect4(32'h1122_3344, 32'hAABB_CCDD, 32'hA0A0_A0A0, 32'hB0B0_B0B0);
        compare4("bypass");
        cycle();

        // x0 write protection alongside a real write
        set_wb(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd30, 32'hFFFF_FFFF);
        set_rd(5'd0, 5'd0, 5'd30, 5'd1);
        expect4(32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1122_3344);
        compare4("x0_wr_same");
        cycle();
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd30, 5'd1, 5'd10);
        expect4(32'h0, 32'hFFFF_FFFF, 32'h1122_3344, 32'hAABB_CCDD);
        compare4("x0_wr_after");

        // Dual write to one address: instr2 wins
        set_wb(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
        set_rd(5'd5, 5'd5, 5'd5, 5'd5);
        expect4(32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222);
        compare4("dual_same");
        cycle();
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect4(32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222);
        compare4("dual_stored");

        // Asynchronous reset between edges, with a write pending
        set_wb(1'b1, 5'd1, 32'h9999_9999, 1'b1, 5'd2, 32'h4444_4444);
        set_rd(5'd1, 5'd2, 5'd30, 5'd5);
        #1 rst_n = 1'b0;
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        compare4("async_rst");
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
        cycle();
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        compare4("post_rst");
        cycle();
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        compare4("post_rst_edge");

        // Randomized traffic over a narrow address range to force collisions
        for (int n = 0; n < 200; n++) begin
            set_wb($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            expect4(model_read(rs.rs1_addr_instr1), model_read(rs.rs2_addr_instr1),
                    model_read(rs.rs1_addr_instr2), model_read(rs.rs2_addr_instr2));
            compare4("rand");
            cycle();
        end

        // Final sweep of stored state for every register
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int a = 0; a < NUM_REGS; a += 4) begin
            set_rd(5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3));
            expect4(model_read(5'(a)), model_read(5'(a + 1)), model_read(5'(a + 2)), model_read(5'(a + 3)));
            compare4("sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
